// File: rtl/porta_pad_coleco.sv
// Two-player controller front-end: synchronised/debounced buttons, optional keypad scan, select-driven output mux.
// Keypad scanning is built only when PORTA_PAD_KEYPAD_EN is defined; otherwise keypad nibbles read as F.
module porta_pad_coleco #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int SCAN_DIV        = 1024
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       C4_ARM,
    input  logic       C7_FIRE,
    input  logic [5:0] P1_BTN,
    input  logic [5:0] P2_BTN,
    output logic [2:0] KP_COL,
    input  logic [3:0] KP1_ROW,
    input  logic [3:0] KP2_ROW,
    output logic       C1P0,
    output logic       C1P1,
    output logic       C1P2,
    output logic       C1P3,
    output logic       C1P5,
    output logic       C1P6,
    output logic       C2P0,
    output logic       C2P1,
    output logic       C2P2,
    output logic       C2P3,
    output logic       C2P5,
    output logic       C2P6
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [11:0] btn_meta_q;
    logic [11:0] btn_sync_q;
    logic [11:0] btn_db;
    logic [3:0]  kp1_nib;
    logic [3:0]  kp2_nib;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
        end else begin
            btn_meta_q <= {P2_BTN, P1_BTN};
            btn_sync_q <= btn_meta_q;
        end
    end

    // Bits [5:0] are player 1, [11:6] player 2; each level must hold DEBOUNCE_CYCLES cycles to be accepted.
    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_q;
            logic             db_q;

            always_ff @(posedge clk or negedge RESETn) begin
                if (!RESETn) begin
                    cnt_q <= '0;
                    db_q  <= 1'b1;
                end else if (btn_sync_q[gi] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_MAX) begin
                    db_q  <= btn_sync_q[gi];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign btn_db[gi] = db_q;
        end
    endgenerate

`ifdef PORTA_PAD_KEYPAD_EN
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COL0,
        S_COL1,
        S_COL2,
        S_COMMIT
    } scan_state_t;

    scan_state_t      state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       kp_col_q;
    logic [3:0]       kp1_row_meta_q, kp1_row_sync_q;
    logic [3:0]       kp2_row_meta_q, kp2_row_sync_q;
    logic [11:0]      kp1_samp_q, kp2_samp_q;
    logic [3:0]       kp1_prev_q, kp2_prev_q;
    logic [3:0]       kp1_nib_q, kp2_nib_q;
    logic [3:0]       kp1_cand, kp2_cand;

    // Sample index is col*4 + row; returns the CPU-visible active-low nibble.
    function automatic logic [3:0] key_code(input int idx);
        logic [3:0] code;
        case (idx)
            0:       code = 4'hD;
            1:       code = 4'h2;
            2:       code = 4'h5;
            3:       code = 4'h6;
            4:       code = 4'h7;
            5:       code = 4'h3;
            6:       code = 4'h1;
            7:       code = 4'hA;
            8:       code = 4'hC;
            9:       code = 4'hE;
            10:      code = 4'hB;
            11:      code = 4'h9;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] scan_candidate(input logic [11:0] samp);
        int         lows;
        logic [3:0] code;
        lows = 0;
        code = 4'hF;
        for (int i = 0; i < 12; i++) begin
            if (!samp[i]) begin
                lows = lows + 1;
                code = key_code(i);
            end
        end
        return (lows == 1) ? code : 4'hF;
    endfunction

    always_comb begin
        kp1_cand = scan_candidate(kp1_samp_q);
        kp2_cand = scan_candidate(kp2_samp_q);
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            kp1_row_meta_q <= '1;
            kp1_row_sync_q <= '1;
            kp2_row_meta_q <= '1;
            kp2_row_sync_q <= '1;
        end else begin
            kp1_row_meta_q <= KP1_ROW;
            kp1_row_sync_q <= kp1_row_meta_q;
            kp2_row_meta_q <= KP2_ROW;
            kp2_row_sync_q <= kp2_row_meta_q;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            kp_col_q   <= 3'b111;
            kp1_samp_q <= '1;
            kp2_samp_q <= '1;
            kp1_prev_q <= 4'hF;
            kp2_prev_q <= 4'hF;
            kp1_nib_q  <= 4'hF;
            kp2_nib_q  <= 4'hF;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_COL0;
                    kp_col_q <= 3'b110;
                    div_q    <= '0;
                end
                S_COL0: begin
                    if (div_q == DIV_MAX) begin
                        div_q            <= '0;
                        kp1_samp_q[3:0]  <= kp1_row_sync_q;
                        kp2_samp_q[3:0]  <= kp2_row_sync_q;
                        state_q          <= S_COL1;
                        kp_col_q         <= 3'b101;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_COL1: begin
                    if (div_q == DIV_MAX) begin
                        div_q            <= '0;
                        kp1_samp_q[7:4]  <= kp1_row_sync_q;
                        kp2_samp_q[7:4]  <= kp2_row_sync_q;
                        state_q          <= S_COL2;
                        kp_col_q         <= 3'b011;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_COL2: begin
                    if (div_q == DIV_MAX) begin
                        div_q            <= '0;
                        kp1_samp_q[11:8] <= kp1_row_sync_q;
                        kp2_samp_q[11:8] <= kp2_row_sync_q;
                        state_q          <= S_COMMIT;
                        kp_col_q         <= 3'b111;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // Publish only when two consecutive scans agree.
                    if (kp1_cand == kp1_prev_q) kp1_nib_q <= kp1_cand;
                    if (kp2_cand == kp2_prev_q) kp2_nib_q <= kp2_cand;
                    kp1_prev_q <= kp1_cand;
                    kp2_prev_q <= kp2_cand;
                    state_q    <= S_COL0;
                    kp_col_q   <= 3'b110;
                    div_q      <= '0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    kp_col_q <= 3'b111;
                    div_q    <= '0;
                end
            endcase
        end
    end

    assign KP_COL  = kp_col_q;
    assign kp1_nib = kp1_nib_q;
    assign kp2_nib = kp2_nib_q;
`else
    logic unused_kp_rows;

    assign unused_kp_rows = ^{KP1_ROW, KP2_ROW};
    assign KP_COL         = 3'b111;
    assign kp1_nib        = 4'hF;
    assign kp2_nib        = 4'hF;
`endif

    // Line vectors are ordered {P6,P5,P3,P2,P1,P0}.
    logic [5:0] c1_d, c1_q;
    logic [5:0] c2_d, c2_q;

    always_comb begin
        c1_d = '1;
        c2_d = '1;
        if (C4_ARM) begin
            c1_d = {1'b1, btn_db[4],  btn_db[3],  btn_db[2],  btn_db[1], btn_db[0]};
            c2_d = {1'b1, btn_db[10], btn_db[9],  btn_db[8],  btn_db[7], btn_db[6]};
        end else if (C7_FIRE) begin
            c1_d = {1'b1, btn_db[5],  kp1_nib[1], kp1_nib[3], kp1_nib[2], kp1_nib[0]};
            c2_d = {1'b1, btn_db[11], kp2_nib[1], kp2_nib[3], kp2_nib[2], kp2_nib[0]};
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            c1_q <= '1;
            c2_q <= '1;
        end else begin
            c1_q <= c1_d;
            c2_q <= c2_d;
        end
    end

    assign {C1P6, C1P5, C1P3, C1P2, C1P1, C1P0} = c1_q;
    assign {C2P6, C2P5, C2P3, C2P2, C2P1, C2P0} = c2_q;

endmodule

// File: tb/tb_porta_pad_coleco.sv
// Directed bench for porta_pad_coleco with short debounce and scan periods.
module tb_porta_pad_coleco;

    localparam int DB = 16;
    localparam int SD = 8;

    logic       clk = 1'b0;
    logic       RESETn, C4_ARM, C7_FIRE;
    logic [5:0] P1_BTN, P2_BTN;
    logic [2:0] KP_COL;
    logic [3:0] KP1_ROW, KP2_ROW;
    logic       C1P0, C1P1, C1P2, C1P3, C1P5, C1P6;
    logic       C2P0, C2P1, C2P2, C2P3, C2P5, C2P6;
    logic [11:0] p1_keys, p2_keys;
    logic [5:0] c1, c2;
    logic [3:0] nib1, nib2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    porta_pad_coleco #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
        .clk(clk), .RESETn(RESETn), .C4_ARM(C4_ARM), .C7_FIRE(C7_FIRE),
        .P1_BTN(P1_BTN), .P2_BTN(P2_BTN), .KP_COL(KP_COL),
        .KP1_ROW(KP1_ROW), .KP2_ROW(KP2_ROW),
        .C1P0(C1P0), .C1P1(C1P1), .C1P2(C1P2), .C1P3(C1P3), .C1P5(C1P5), .C1P6(C1P6),
        .C2P0(C2P0), .C2P1(C2P1), .C2P2(C2P2), .C2P3(C2P3), .C2P5(C2P5), .C2P6(C2P6)
    );

    assign c1   = {C1P6, C1P5, C1P3, C1P2, C1P1, C1P0};
    assign c2   = {C2P6, C2P5, C2P3, C2P2, C2P1, C2P0};
    assign nib1 = {C1P2, C1P1, C1P3, C1P0};
    assign nib2 = {C2P2, C2P1, C2P3, C2P0};

    // Keypad matrix model: a held key pulls its row low while its column is driven low.
    always_comb begin
        KP1_ROW = 4'hF;
        KP2_ROW = 4'hF;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!KP_COL[c] && p1_keys[c*4+r]) KP1_ROW[r] = 1'b0;
                if (!KP_COL[c] && p2_keys[c*4+r]) KP2_ROW[r] = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        RESETn = 1'b0; C4_ARM = 1'b1; C7_FIRE = 1'b0;
        P1_BTN = 6'h3F; P2_BTN = 6'h3F; p1_keys = '0; p2_keys = '0;
        #12;
        total++; if (c1 !== 6'h3F) begin bad++; $display("FAIL reset_c1 got=%b exp=%b", c1, 6'h3F); end
        total++; if (c2 !== 6'h3F) begin bad++; $display("FAIL reset_c2 got=%b exp=%b", c2, 6'h3F); end
        total++; if (KP_COL !== 3'b111) begin bad++; $display("FAIL reset_kpcol got=%b exp=111", KP_COL); end
        @(negedge clk) RESETn = 1'b1;
        tick(5);
        total++; if (c1 !== 6'h3F) begin bad++; $display("FAIL idle_c1 got=%b exp=%b", c1, 6'h3F); end
        total++; if (c2 !== 6'h3F) begin bad++; $display("FAIL idle_c2 got=%b exp=%b", c2, 6'h3F); end
`ifdef PORTA_PAD_KEYPAD_EN
        total++; if (KP_COL !== 3'b110) begin bad++; $display("FAIL idle_kpcol got=%b exp=110", KP_COL); end
`else
        total++; if (KP_COL !== 3'b111) begin bad++; $display("FAIL idle_kpcol got=%b exp=111", KP_COL); end
`endif
        $display("reset: c1=%b c2=%b kp_col=%b", c1, c2, KP_COL);
    endtask

    task automatic test_joystick;
        int  first;
        bit  c2_moved;
        bit  p3_moved;
        first = 0; c2_moved = 0; p3_moved = 0;
        C4_ARM = 1'b1; C7_FIRE = 1'b0;
        P1_BTN[0] = 1'b0;
        for (int n = 1; n <= DB + 8; n++) begin
            tick(1);
            if (first == 0 && C1P0 === 1'b0) first = n;
            if (c2 !== 6'h3F) c2_moved = 1;
        end
        total++; if (first < DB + 1 || first > DB + 4) begin bad++; $display("FAIL joy_latency got=%0d exp=%0d..%0d", first, DB + 1, DB + 4); end
        total++; if (c1 !== 6'b111110) begin bad++; $display("FAIL joy_up_c1 got=%b exp=111110", c1); end
        total++; if (c2_moved) begin bad++; $display("FAIL joy_p2_quiet got=moved exp=all ones"); end
        $display("joystick up: first_low_cycle=%0d c1=%b", first, c1);

        P1_BTN[3] = 1'b0;
        for (int n = 0; n < DB - 4; n++) begin tick(1); if (C1P3 !== 1'b1) p3_moved = 1; end
        P1_BTN[3] = 1'b1;
        for (int n = 0; n < 2 * DB; n++) begin tick(1); if (C1P3 !== 1'b1) p3_moved = 1; end
        total++; if (p3_moved) begin bad++; $display("FAIL joy_glitch got=C1P3 moved exp=stays 1"); end
        $display("joystick glitch on right: moved=%0d", p3_moved);

        P1_BTN[0] = 1'b1;
        P2_BTN[2] = 1'b0;
        tick(DB + 6);
        total++; if (c1 !== 6'h3F) begin bad++; $display("FAIL joy_release got=%b exp=111111", c1); end
        total++; if (c2 !== 6'b111011) begin bad++; $display("FAIL joy_p2_left got=%b exp=111011", c2); end
        $display("joystick p2 left: c1=%b c2=%b", c1, c2);
        P2_BTN[2] = 1'b1;
        tick(DB + 6);
    endtask

    task automatic test_select;
        C4_ARM = 1'b1; C7_FIRE = 1'b0;
        P1_BTN[5:4] = 2'b00;
        tick(DB + 6);
        total++; if (c1 !== 6'b101111) begin bad++; $display("FAIL sel_joy_fire got=%b exp=101111", c1); end
        C4_ARM = 1'b0; C7_FIRE = 1'b1;
        tick(1);
        total++; if (c1 !== 6'b101111) begin bad++; $display("FAIL sel_kp_fire got=%b exp=101111", c1); end
        $display("select keypad, both fires held: c1=%b", c1);
        P1_BTN[5] = 1'b1;
        tick(DB + 6);
        total++; if (c1 !== 6'h3F) begin bad++; $display("FAIL sel_kp_firer_rel got=%b exp=111111", c1); end
        C4_ARM = 1'b1; C7_FIRE = 1'b1;
        tick(1);
        total++; if (c1 !== 6'b101111) begin bad++; $display("FAIL sel_priority got=%b exp=101111", c1); end
        C4_ARM = 1'b0; C7_FIRE = 1'b0;
        tick(1);
        total++; if (c1 !== 6'h3F || c2 !== 6'h3F) begin bad++; $display("FAIL sel_none got=%b/%b exp=111111/111111", c1, c2); end
        $display("select none: c1=%b c2=%b", c1, c2);
        P1_BTN = 6'h3F;
        tick(DB + 6);
    endtask

`ifdef PORTA_PAD_KEYPAD_EN
    task automatic test_keypad;
        bit found;
        found = 0;
        C4_ARM = 1'b0; C7_FIRE = 1'b1;
        p1_keys = '0; p2_keys = '0;
        p1_keys[5] = 1'b1;
        p2_keys[11] = 1'b1;
        @(posedge clk); #1 RESETn = 1'b0;
        #2 RESETn = 1'b1;
        tick(40);
        total++; if (nib1 !== 4'hF) begin bad++; $display("FAIL kp_one_scan_p1 got=%h exp=f", nib1); end
        total++; if (nib2 !== 4'hF) begin bad++; $display("FAIL kp_one_scan_p2 got=%h exp=f", nib2); end
        tick(20);
        total++; if (nib1 !== 4'h3) begin bad++; $display("FAIL kp_key5 got=%h exp=3", nib1); end
        total++; if (nib2 !== 4'h9) begin bad++; $display("FAIL kp_keyhash got=%h exp=9", nib2); end
        total++; if ({C1P6, C1P5} !== 2'b11) begin bad++; $display("FAIL kp_p65 got=%b exp=11", {C1P6, C1P5}); end
        $display("keypad 5/#: nib1=%h nib2=%h", nib1, nib2);

        p1_keys = '0;
        p1_keys[0] = 1'b1;
        p1_keys[4] = 1'b1;
        tick(80);
        total++; if (nib1 !== 4'hF) begin bad++; $display("FAIL kp_multikey got=%h exp=f", nib1); end
        total++; if (nib2 !== 4'h9) begin bad++; $display("FAIL kp_p2_hold got=%h exp=9", nib2); end
        $display("keypad 1+2: nib1=%h nib2=%h", nib1, nib2);

        for (int n = 0; n < 60 && !found; n++) begin tick(1); if (KP_COL === 3'b101) found = 1; end
        total++; if (!found) begin bad++; $display("FAIL kp_reach_col1 got=timeout exp=kp_col 101"); end
        tick(2);
        total++; if (c2 !== 6'b110101) begin bad++; $display("FAIL kp_pre_reset_c2 got=%b exp=110101", c2); end
        RESETn = 1'b0;
        #1;
        total++; if (KP_COL !== 3'b111) begin bad++; $display("FAIL kp_rst_kpcol got=%b exp=111", KP_COL); end
        total++; if (c1 !== 6'h3F || c2 !== 6'h3F) begin bad++; $display("FAIL kp_rst_out got=%b/%b exp=111111/111111", c1, c2); end
        $display("reset during col1: kp_col=%b c1=%b c2=%b", KP_COL, c1, c2);
        @(negedge clk) RESETn = 1'b1;
        tick(1);
        total++; if (KP_COL !== 3'b110) begin bad++; $display("FAIL kp_restart_col0 got=%b exp=110", KP_COL); end
        tick(SD - 1);
        total++; if (KP_COL !== 3'b110) begin bad++; $display("FAIL kp_col0_hold got=%b exp=110", KP_COL); end
        tick(1);
        total++; if (KP_COL !== 3'b101) begin bad++; $display("FAIL kp_col1_step got=%b exp=101", KP_COL); end
        $display("scan restart: kp_col=%b", KP_COL);
        p1_keys = '0; p2_keys = '0;
        tick(60);
    endtask
`else
    task automatic test_keypad_disabled;
        bit col_moved;
        col_moved = 0;
        C4_ARM = 1'b0; C7_FIRE = 1'b1;
        p1_keys = '0; p1_keys[5] = 1'b1;
        for (int n = 0; n < 80; n++) begin tick(1); if (KP_COL !== 3'b111) col_moved = 1; end
        total++; if (col_moved) begin bad++; $display("FAIL kpoff_kpcol got=moved exp=111"); end
        total++; if (nib1 !== 4'hF || nib2 !== 4'hF) begin bad++; $display("FAIL kpoff_nib got=%h/%h exp=f/f", nib1, nib2); end
        P1_BTN[5] = 1'b0;
        tick(DB + 6);
        total++; if (c1 !== 6'b101111) begin bad++; $display("FAIL kpoff_firer got=%b exp=101111", c1); end
        $display("keypad disabled: kp_col=%b c1=%b", KP_COL, c1);
        P1_BTN = 6'h3F; p1_keys = '0;
        tick(DB + 6);
    endtask
`endif

    task automatic test_async_reset;
        C4_ARM = 1'b1; C7_FIRE = 1'b0;
        P1_BTN[0] = 1'b0;
        tick(DB + 6);
        total++; if (C1P0 !== 1'b0) begin bad++; $display("FAIL arst_pre got=%b exp=0", C1P0); end
        RESETn = 1'b0;
        #1;
        total++; if (c1 !== 6'h3F) begin bad++; $display("FAIL arst_c1 got=%b exp=111111", c1); end
        total++; if (KP_COL !== 3'b111) begin bad++; $display("FAIL arst_kpcol got=%b exp=111", KP_COL); end
        $display("async reset: c1=%b kp_col=%b", c1, KP_COL);
        P1_BTN = 6'h3F;
        @(negedge clk) RESETn = 1'b1;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_joystick();
        test_select();
`ifdef PORTA_PAD_KEYPAD_EN
        test_keypad();
`else
        test_keypad_disabled();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/porta_pad_coleco.md
Name: porta_pad_coleco

Overview:
- Controller front-end for the 2-player portable; sits directly upstream of the glue logic.
- Synchronises and debounces raw active-low buttons for both players, and optionally scans two 12-key keypads.
- Drives C1P0..C1P6 and C2P0..C2P6 according to the controller select lines C4_ARM and C7_FIRE produced by the glue logic.

Parameters:
- DEBOUNCE_CYCLES, 4096, consecutive clk cycles a synchronised input must differ from its debounced value before it is accepted (>=2).
- SCAN_DIV, 1024, clk cycles each keypad column is driven before its rows are sampled (>=4).

Ports:
- clk  input  1  system clock; all logic on posedge.
- RESETn  input  1  asynchronous active-low reset.
- C4_ARM  input  1  joystick-mode select from glue logic, active-high.
- C7_FIRE  input  1  keypad-mode select from glue logic, active-high.
- P1_BTN  input  6  player 1 raw buttons, active-low: [0]up [1]down [2]left [3]right [4]fire_l [5]fire_r.
- P2_BTN  input  6  player 2 raw buttons, same bit map.
- KP_COL  output  3  keypad column drive shared by both keypads, active-low, one column low at a time.
- KP1_ROW  input  4  player 1 keypad rows, active-low, pulled up externally.
- KP2_ROW  input  4  player 2 keypad rows, same.
- C1P0, C1P1, C1P2, C1P3, C1P5, C1P6  output  1 each  player 1 controller lines to glue, active-low.
- C2P0, C2P1, C2P2, C2P3, C2P5, C2P6  output  1 each  player 2 controller lines, same.

Behaviour:
- Reset: all debounced buttons = 1 (released); keypad codes = 4'hF; KP_COL = 3'b111; all CxPy = 1; counters = 0; scan FSM in IDLE.
- Sync: every raw input, buttons and rows, passes a 2-flop synchroniser; nothing asynchronous reaches debounce or scan logic.
- Debounce, per button:
  - Counter clears whenever the synchronised value equals the debounced value.
  - Otherwise the counter increments.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced value takes the new level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Mode select, evaluated each cycle, with this priority:
  - C4_ARM=1: joystick mode. P0=up, P1=down, P2=left, P3=right, P5=fire_l, P6=1.
  - Else C7_FIRE=1: keypad mode. {P2,P1,P3,P0} = keypad nibble (D3..D0 order at glue), P5=fire_r, P6=1.
  - Else: all P lines = 1.
- Output timing:
  - CxPy are registered; output latency is one clk after a select or debounced-value change.
  - Select changes take effect with no debounce.
- Keypad nibble codes (active-low as read by CPU): 0=A, 1=D, 2=7, 3=C, 4=2, 5=3, 6=E, 7=5, 8=1, 9=B, *=6, #=9, none=F.
- Key layout: column 0 = {1,4,7,*}, column 1 = {2,5,8,0}, column 2 = {3,6,9,#}; row index 0..3 top to bottom.
- Scan FSM states:
  - IDLE: one cycle, then COL0.
  - COL0 / COL1 / COL2: drive KP_COL low on that column for SCAN_DIV cycles; sample both row sets on the last cycle; advance to the next column.
  - COMMIT (after COL2): one cycle with KP_COL=111; then return to COL0.
- COMMIT rules, per player:
  - Exactly one key low across the 12 samples gives its code as the candidate.
  - Zero keys or two or more keys give F as the candidate.
  - The published nibble updates only when the candidate equals the previous scan's candidate, i.e. two matching consecutive scans.
- Reset mid-scan: FSM returns to IDLE, KP_COL=111, published nibbles = F.
- No simultaneous-event ambiguity: keypad publication and debounce run independently; output mux always uses the current published values.

Optional Feature:
- Macro: PORTA_PAD_KEYPAD_EN.
- Defined: keypad scan FSM built as above.
- Undefined: no FSM; KP_COL held at 3'b111; KPx_ROW ignored; keypad nibbles constant F. Keypad mode still drives P5=fire_r, so two-button games keep working.

Test Plan:
- Reset release, C4_ARM=1, C7_FIRE=0, all buttons released -> all CxPy=1, KP_COL=111.
- Joystick press: C4_ARM=1, P1_BTN[0] low for DEBOUNCE_CYCLES+3 cycles -> C1P0=0 within DEBOUNCE_CYCLES+4 cycles, C2P0 stays 1. Then a 100-cycle pulse on P1_BTN[3] -> C1P3 never changes.
- Select switch: hold P1 fire_l and fire_r debounced low, toggle to C4_ARM=0, C7_FIRE=1 -> C1P5 stays 0 (now fire_r), C1P0..C1P3=1 with no key pressed; both selects 0 -> all 1 next cycle.
- Keypad (macro defined): P1 key '5' (column 1, row 1) held for 3 scans, C7_FIRE=1 -> {C1P2,C1P1,C1P3,C1P0}=4'h3 after second full scan.
- Keypad multi-key: '1' and '2' held -> nibble F; with macro undefined, '5' held -> nibble stays F and KP_COL=111.
- Async reset asserted during COL1 -> KP_COL=111 and all outputs 1 immediately; scan restarts from COL0 after release.
